ula_sequenciador: RTL and testbench

Command sequencer that drives the 8-bit ALU. It accepts an operation and two operands from a host over a valid/ready handshake, and holds them on the ALU's operand and opcode lines for a programmable number of settling cycles. It then captures the ALU result and flags into registers and returns them over a second valid/ready handshake. It sits between the host/control logic (switches, test controller) and the combinational ALU, and is the ALU's only driver.

---
 rtl/ula_sequenciador.sv | 129 ++++++++++++
 tb/tb_ula_sequenciador.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_sequenciador.sv
// Command sequencer for the 8-bit ALU: accepts a command, holds ALU inputs LATENCIA cycles, captures result/flags.
// Optional accumulator feedback on operand A is enabled with `define ULA_SEQ_ACUMULADOR_EN.
module ula_sequenciador #(
  parameter int unsigned LATENCIA = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic [2:0] cmd_op,
  input  logic       cmd_usa_acc,
  output logic [7:0] ula_a,
  output logic [7:0] ula_b,
  output logic [2:0] ula_operacao,
  input  logic [7:0] ula_resultado,
  input  logic       ula_overflow,
  input  logic       ula_zero,
  input  logic       ula_carry_out,
  input  logic       ula_erro,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_dado,
  output logic [3:0] res_flags,
  output logic [7:0] contador_erros,
  output logic [1:0] estado_dbg
);

  if (LATENCIA < 1 || LATENCIA > 15) begin : g_latencia_invalida
    $error("ula_sequenciador: LATENCIA must be in 1..15");
  end

  localparam logic [3:0] LATENCIA_CNT = 4'(LATENCIA);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // cmd_* must be held by the host until accepted; res_dado/res_flags stay stable while res_valid is high.
  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    ESPERA    = 2'd1,
    RESULTADO = 2'd2
  } estado_t;

  estado_t    estado;
  estado_t    proximo;
  logic [3:0] contador;
  logic       aceita;
  logic       captura;
  logic [7:0] operando_a;

  assign estado_dbg = estado;

  always_ff @(posedge clk) begin
    if (rst) estado <= OCIOSO;
    else     estado <= proximo;
  end

  always_comb begin
    proximo   = estado;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    aceita    = 1'b0;
    captura   = 1'b0;
    case (estado)
      OCIOSO: begin
        cmd_ready = !rst;
        if (cmd_valid && !rst) begin
          aceita  = 1'b1;
          proximo = ESPERA;
        end
      end
      ESPERA: begin
        if (contador == 4'd1) begin
          captura = 1'b1;
          proximo = RESULTADO;
        end
      end
      RESULTADO: begin
        res_valid = 1'b1;
        if (res_ready) proximo = OCIOSO;
      end
      default: proximo = OCIOSO;
    endcase
  end

`ifdef ULA_SEQ_ACUMULADOR_EN
  logic [7:0] acumulador;

  assign operando_a = cmd_usa_acc ? acumulador : cmd_a;

  always_ff @(posedge clk) begin
    if (rst)          acumulador <= 8'h00;
    else if (captura) acumulador <= ula_resultado;
  end
`else
  // Without the accumulator the selector has no effect; keep the port so both builds share a pinout.
  logic cmd_usa_acc_unused;
  assign cmd_usa_acc_unused = cmd_usa_acc;
  assign operando_a         = cmd_a;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ula_a          <= 8'h00;
      ula_b          <= 8'h00;
      ula_operacao   <= 3'b000;
      contador       <= 4'd0;
      res_dado       <= 8'h00;
      res_flags      <= 4'h0;
      contador_erros <= 8'h00;
    end else begin
      if (aceita) begin
        ula_a        <= operando_a;
        ula_b        <= cmd_b;
        ula_operacao <= cmd_op;
        contador     <= LATENCIA_CNT;
      end else if (estado == ESPERA) begin
        contador <= contador - 4'd1;
      end
      if (captura) begin
        res_dado  <= ula_resultado;
        res_flags <= {ula_overflow, ula_zero, ula_carry_out, ula_erro};
        if (ula_erro && contador_erros != 8'hFF)
          contador_erros <= contador_erros + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ula_sequenciador.sv
// Directed bench: three sequencers (LATENCIA 1, 4, 8) share host stimulus, each driving its own ALU model.
module tb_ula_sequenciador;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_usa_acc = 1'b0;
  logic       res_ready = 1'b0;
  logic [7:0] cmd_a = 8'h00;
  logic [7:0] cmd_b = 8'h00;
  logic [2:0] cmd_op = 3'b000;

  logic        cmd_ready      [3];
  logic [7:0]  ula_a          [3];
  logic [7:0]  ula_b          [3];
  logic [2:0]  ula_operacao   [3];
  logic [11:0] alu_out        [3];
  logic        res_valid      [3];
  logic [7:0]  res_dado       [3];
  logic [3:0]  res_flags      [3];
  logic [7:0]  contador_erros [3];
  logic [1:0]  estado_dbg     [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // ALU reference: returns {overflow, zero, carry_out, erro, result}
  function automatic logic [11:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    logic [8:0]  s;
    logic [15:0] p;
    logic [7:0]  r;
    logic        ov, c, e;
    ov = 1'b0; c = 1'b0; e = 1'b0; r = 8'h00; s = 9'd0; p = 16'd0;
    case (op)
      3'b000: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; ov = (a[7] == b[7]) && (r[7] != a[7]); end
      3'b001: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = s[8]; ov = (a[7] != b[7]) && (r[7] != a[7]); end
      3'b010: begin p = a * b; r = p[7:0]; ov = |p[15:8]; end
      3'b011: begin if (b == 8'h00) e = 1'b1; else r = a / b; end
      3'b100: r = a & b;
      3'b101: r = a | b;
      3'b110: r = a ^ b;
      default: r = ~a;
    endcase
    return {ov, (r == 8'h00) && !e, c, e, r};
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_dut
    assign alu_out[k] = alu_model(ula_a[k], ula_b[k], ula_operacao[k]);
    ula_sequenciador #(.LATENCIA(k == 0 ? 1 : (k == 1 ? 4 : 8))) dut (
      .clk            (clk),
      .rst            (rst),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready[k]),
      .cmd_a          (cmd_a),
      .cmd_b          (cmd_b),
      .cmd_op         (cmd_op),
      .cmd_usa_acc    (cmd_usa_acc),
      .ula_a          (ula_a[k]),
      .ula_b          (ula_b[k]),
      .ula_operacao   (ula_operacao[k]),
      .ula_resultado  (alu_out[k][7:0]),
      .ula_overflow   (alu_out[k][11]),
      .ula_zero       (alu_out[k][10]),
      .ula_carry_out  (alu_out[k][9]),
      .ula_erro       (alu_out[k][8]),
      .res_valid      (res_valid[k]),
      .res_ready      (res_ready),
      .res_dado       (res_dado[k]),
      .res_flags      (res_flags[k]),
      .contador_erros (contador_erros[k]),
      .estado_dbg     (estado_dbg[k])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic usa);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_usa_acc = usa;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_usa_acc = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    res_ready = 1'b1;
    while (!(cmd_ready[0] && cmd_ready[1] && cmd_ready[2]) && n < 40) begin
      tick();
      n++;
    end
    chk("drain_all_idle", {31'd0, cmd_ready[0] && cmd_ready[1] && cmd_ready[2]}, 32'd1);
    res_ready = 1'b0;
  endtask

  task automatic chk_reset(input int k);
    chk("rst_res_valid", res_valid[k], 0);
    chk("rst_res_dado", res_dado[k], 8'h00);
    chk("rst_res_flags", res_flags[k], 4'h0);
    chk("rst_ula_a", ula_a[k], 8'h00);
    chk("rst_ula_b", ula_b[k], 8'h00);
    chk("rst_ula_op", ula_operacao[k], 3'b000);
    chk("rst_cnt_erros", contador_erros[k], 8'h00);
    chk("rst_estado", estado_dbg[k], 2'd0);
  endtask

  logic [7:0] exp_acc_a;
  logic [7:0] exp_acc_res;

  initial begin
    // reset
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("rst_cmd_ready_low", cmd_ready[k], 0);
      chk_reset(k);
    end
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) chk("post_rst_cmd_ready", cmd_ready[k], 1);

    // add 7F+01, LATENCIA=1
    send(8'h7F, 8'h01, 3'b000, 1'b0);
    chk("add_ula_a", ula_a[0], 8'h7F);
    chk("add_ula_b", ula_b[0], 8'h01);
    chk("add_ula_op", ula_operacao[0], 3'b000);
    chk("add_cmd_ready_busy", cmd_ready[0], 0);
    chk("add_valid_early", res_valid[0], 0);
    tick();
    chk("add_valid", res_valid[0], 1);
    chk("add_dado", res_dado[0], 8'h80);
    chk("add_flags", res_flags[0], 4'b1000);
    chk("add_estado", estado_dbg[0], 2'd2);
    drain();

    // sub 05-05, LATENCIA=4: valid exactly 4 cycles after accept
    send(8'h05, 8'h05, 3'b001, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      chk("sub_ula_a_stable", ula_a[1], 8'h05);
      tick();
      chk("sub_valid_timing", res_valid[1], (i == 4) ? 1 : 0);
    end
    chk("sub_dado", res_dado[1], 8'h00);
    chk("sub_flags", res_flags[1], 4'b0100);
    drain();

    // reset during the 3rd wait cycle of LATENCIA=8, with an erroring command in flight
    send(8'h09, 8'h00, 3'b011, 1'b0);
    tick();
    tick();
    chk("mid_estado_espera", estado_dbg[2], 2'd1);
    rst = 1'b1;
    tick();
    chk("mid_cmd_ready_rst", cmd_ready[2], 0);
    chk_reset(2);
    rst = 1'b0;
    #1;
    chk("mid_cmd_ready_after", cmd_ready[2], 1);
    repeat (12) tick();
    chk("mid_no_capture", res_valid[2], 0);
    chk("mid_cnt_erros", contador_erros[2], 8'h00);

    // divide by zero: error counter increments once per capture and saturates
    for (int i = 1; i <= 300; i++) begin
      send(8'h09, 8'h00, 3'b011, 1'b0);
      if (i == 1) begin
        tick();
        chk("div_flags", res_flags[0], 4'b0001);
        chk("div_dado", res_dado[0], 8'h00);
        chk("div_cnt_first", contador_erros[0], 8'h01);
        tick();
        chk("div_cnt_held", contador_erros[0], 8'h01);
      end
      drain();
      if (i == 254) chk("div_cnt_254", contador_erros[0], 8'hFE);
      if (i == 255) chk("div_cnt_255", contador_erros[2], 8'hFF);
    end
    chk("div_sat_lat1", contador_erros[0], 8'hFF);
    chk("div_sat_lat4", contador_erros[1], 8'hFF);

    // backpressure: result held for 5 cycles while a new command waits
    send(8'h10, 8'h20, 3'b000, 1'b0);
    tick();
    cmd_a = 8'h01; cmd_b = 8'h01; cmd_op = 3'b000;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", res_valid[0], 1);
      chk("bp_dado", res_dado[0], 8'h30);
      chk("bp_cmd_ready", cmd_ready[0], 0);
      chk("bp_no_accept", ula_a[0], 8'h10);
      tick();
    end
    res_ready = 1'b1;
    chk("bp_valid_6th", res_valid[0], 1);
    tick();
    chk("bp_consumed", res_valid[0], 0);
    chk("bp_cmd_ready_after", cmd_ready[0], 1);
    chk("bp_ula_a_kept", ula_a[0], 8'h10);
    chk("bp_dado_kept", res_dado[0], 8'h30);
    cmd_valid = 1'b0;
    drain();

    // accumulator chaining
`ifdef ULA_SEQ_ACUMULADOR_EN
    exp_acc_a   = 8'h07;
    exp_acc_res = 8'h17;
`else
    exp_acc_a   = 8'h50;
    exp_acc_res = 8'h60;
`endif
    send(8'h03, 8'h04, 3'b000, 1'b0);
    tick();
    chk("acc_first", res_dado[0], 8'h07);
    drain();
    send(8'h50, 8'h10, 3'b000, 1'b1);
    chk("acc_ula_a", ula_a[2], {24'd0, exp_acc_a});
    tick();
    chk("acc_second_lat1", res_dado[0], {24'd0, exp_acc_res});
    drain();
    chk("acc_second_lat8", res_dado[2], {24'd0, exp_acc_res});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=done");
    $fatal(1, "watchdog expired");
  end

endmodule
